demux_8bits_buffered: RTL

- 1-to-2 demultiplexer for 8-bit words; the inverse of the team's 2:1 8-bit mux.
- Accepts one input word stream plus a per-word select and steers each word to channel A or channel B.
- Polarity matches the mux: sel=1 routes to A, sel=0 routes to B.
- Each channel has its own small FIFO, valid/ready handshake, occupancy level and delivered-word counter, so one stalled consumer does not corrupt the other channel.

---
 rtl/demux_8bits_buffered.sv | 85 ++++++++
 1 files changed

// File: rtl/demux_8bits_buffered.sv
// demux_8bits_buffered: 1:2 word demux steering each word into a per-channel FIFO (sel=1 -> A, sel=0 -> B)
module demux_8bits_buffered #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int LVL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [LVL_W-1:0] a_level,
  output logic [LVL_W-1:0] b_level,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [2][DEPTH];
  logic [WIDTH-1:0] mem_d [2][DEPTH];
  logic [PW-1:0]    wp_q [2];
  logic [PW-1:0]    wp_d [2];
  logic [PW-1:0]    rp_q [2];
  logic [PW-1:0]    rp_d [2];
  logic [LVL_W-1:0] lvl_q [2];
  logic [LVL_W-1:0] lvl_d [2];
  logic [CNT_W-1:0] cnt_q [2];
  logic [CNT_W-1:0] cnt_d [2];
  logic [1:0]       push, pop, rdy;
  // index 0 is channel A, index 1 is channel B; full is judged on level only, no same-cycle pop lookahead
  assign in_ready = in_sel ? (lvl_q[0] != LVL_W'(DEPTH)) : (lvl_q[1] != LVL_W'(DEPTH));
  assign rdy      = {b_ready, a_ready};
  assign push     = {in_valid & in_ready & ~in_sel, in_valid & in_ready & in_sel};
  assign pop      = {rdy[1] & (lvl_q[1] != '0), rdy[0] & (lvl_q[0] != '0)};
  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    lvl_d = lvl_q;
    cnt_d = cnt_q;
    for (int c = 0; c < 2; c++) begin
      if (push[c]) begin
        mem_d[c][wp_q[c]] = in_data;
        wp_d[c]           = wp_q[c] + 1'b1;
      end
      if (pop[c]) begin
        rp_d[c]  = rp_q[c] + 1'b1;
        cnt_d[c] = cnt_q[c] + 1'b1;
      end
      lvl_d[c] = lvl_q[c] + LVL_W'(push[c]) - LVL_W'(pop[c]);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < DEPTH; i++) mem_q[c][i] <= '0;
        wp_q[c]  <= '0;
        rp_q[c]  <= '0;
        lvl_q[c] <= '0;
        cnt_q[c] <= '0;
      end
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end
  assign a_data  = mem_q[0][rp_q[0]];
  assign b_data  = mem_q[1][rp_q[1]];
  assign a_valid = lvl_q[0] != '0;
  assign b_valid = lvl_q[1] != '0;
  assign a_level = lvl_q[0];
  assign b_level = lvl_q[1];
  assign a_count = cnt_q[0];
  assign b_count = cnt_q[1];
endmodule
